// File: rtl/bus_memory_responder.sv
// Single-port word memory behind a valid/ready bus with a fixed number of wait states.
// Optional range checking with a bus_error output is enabled by defining BUS_MEMORY_RESPONDER_RANGE_CHECK_EN.
module bus_memory_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_vaild,
    output logic        bus_ready,
    input  logic        bus_write_enable,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_data
`ifdef BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
    ,
    output logic        bus_error
`endif
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                capture;

    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                oor_q;
    logic                oor_d;

    logic [31:0]         mem [0:DEPTH-1];

`ifdef BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
    logic [1:0] unused_addr_bits;
    assign unused_addr_bits = bus_address[1:0];
    assign oor_d            = |bus_address[31:ADDR_W+2];
`else
    // Upper address bits are deliberately ignored so the memory aliases across the address space.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_address[1:0], bus_address[31:ADDR_W+2]};
    assign oor_d            = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_vaild) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESPOND;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                // A dropped request abandons the transaction before any response or write.
                if (!bus_vaild) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= bus_write_enable;
                idx_q   <= bus_address[ADDR_W+1:2];
                wdata_q <= bus_write_data;
                be_q    <= bus_byte_enable;
                oor_q   <= oor_d;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents survive reset and only the control path is cleared.
    always_ff @(posedge clock) begin
        if (state_q == RESPOND && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Outputs decode the registered state, so an asynchronous reset clears them at once.
    assign bus_ready = (state_q == RESPOND);
    assign bus_data  = (state_q == RESPOND && !we_q && !oor_q) ? mem[idx_q] : 32'd0;

`ifdef BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
    assign bus_error = (state_q == RESPOND) && oor_q;
`endif

endmodule

// File: doc/bus_memory_responder.md
BUS_MEMORY_RESPONDER -- requirements
Module: bus_memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning wait cycles inserted per transaction (0..15).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bus_vaild  input  1  initiator request valid, held until bus_ready seen.
REQ-006 SHALL have port bus_ready  output  1  one-cycle transaction-complete strobe.
REQ-007 SHALL have port bus_write_enable  input  1  1 = write, 0 = read.
REQ-008 SHALL have port bus_address  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port bus_write_data  input  32  write data, sampled at request capture.
REQ-010 SHALL have port bus_byte_enable  input  4  per-byte write mask; bit i covers bits [8i+7:8i].
REQ-011 SHALL have port bus_data  output  32  read data, valid only while bus_ready=1.

Function
REQ-012 SHALL implement a storage array of 2^ADDR_W 32-bit words indexed by bus_address[ADDR_W+1:2].
REQ-013 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-014 IDLE with bus_vaild=1 SHALL capture write flag, word index, write data and byte enables; go to WAIT loading counter=WAIT_STATES-1, or go directly to RESPOND if WAIT_STATES=0.
REQ-015 WAIT SHALL decrement counter each cycle and go to RESPOND when counter=0.
REQ-016 RESPOND SHALL drive bus_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency SHALL be WAIT_STATES+1 cycles from capture edge to the cycle with bus_ready=1.
REQ-018 Read: bus_data SHALL equal the addressed word during RESPOND and 0 in all other cycles.
REQ-019 Write: masked bytes SHALL commit on the clock edge ending RESPOND; bus_data SHALL be 0 during a write response.
REQ-020 bus_vaild deasserted in WAIT SHALL abort: return to IDLE next edge, no bus_ready, no memory update.
REQ-021 Inputs changing after capture SHALL not affect the in-flight transaction.
REQ-022 A request held at the cycle after RESPOND SHALL be captured as a new transaction (back-to-back allowed, one IDLE cycle between responses).
REQ-023 bus_byte_enable=0000 write SHALL complete normally with memory unchanged.

Reset
REQ-024 Reset asserted SHALL immediately force IDLE, bus_ready=0, bus_data=0, counter=0, captured fields=0.
REQ-025 Reset mid-transaction SHALL abort it with no memory update; memory contents are not reset.

Configuration
REQ-026 Macro BUS_MEMORY_RESPONDER_RANGE_CHECK_EN defined SHALL add output bus_error (1 bit, reset 0), asserted with bus_ready when bus_address[31:ADDR_W+2] is nonzero; the write is suppressed and bus_data=0.
REQ-027 Without BUS_MEMORY_RESPONDER_RANGE_CHECK_EN, bus_error SHALL not exist and upper address bits SHALL be ignored (aliasing).

Verification
REQ-028 Write 0xDEADBEEF to 0x0000_0010 BE=1111, read 0x10 -> bus_ready 3 cycles after capture (WAIT_STATES=2), bus_data=0xDEADBEEF.
REQ-029 Write 0x11223344 then BE=0010 write 0xAABBCCDD to same address, read -> 0x1122CC44.
REQ-030 WAIT_STATES=0, back-to-back reads of 0x0 and 0x4 with bus_vaild held -> bus_ready in cycles 1 and 3 after first capture.
REQ-031 Write 0x55 to 0x20, drop bus_vaild in first WAIT cycle -> no bus_ready; later read 0x20 returns prior value.
REQ-032 Assert reset in WAIT of a write -> bus_ready=0, bus_data=0 same cycle, memory unchanged, next request served normally.
REQ-033 With macro, read 0x0000_1000 (ADDR_W=10) -> bus_ready=1, bus_error=1, bus_data=0; without macro -> data of word 0.
